// File: rtl/conv1d_stream_layer.sv
// conv1d_stream_layer
//   Streaming 1-D convolution layer with a run-time loadable filter.
//   A filter f[0..LENF-1] is loaded over the f stream and retained.
//   Each input vector x[0..LENX-1] is buffered, then the block emits
//   y[m] = sum_k x[m+k]*f[k] for m = 0..LENX-LENF. Each y is optionally
//   saturated (SAT) or wrapped to WIDTH bits, then optionally rectified (RELU).
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   s_data_in_f   filter coefficient (signed), f[0] first
//   s_valid_f     filter word valid
//   s_ready_f     filter word accepted on s_valid_f && s_ready_f
//   s_data_in_x   input sample (signed), x[0] first
//   s_valid_x     input word valid
//   s_ready_x     input word accepted on s_valid_x && s_ready_x
//   m_data_out_y  output sample (signed), y[0] first
//   m_valid_y     output valid
//   m_ready_y     downstream ready
module conv1d_stream_layer #(
  parameter int WIDTH = 16,
  parameter int LENX  = 64,
  parameter int LENF  = 33,
  parameter int SAT   = 1,
  parameter int RELU  = 0,
  parameter int ACCW  = 2*WIDTH + $clog2(LENF)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] s_data_in_f,
  input  logic                    s_valid_f,
  output logic                    s_ready_f,
  input  logic signed [WIDTH-1:0] s_data_in_x,
  input  logic                    s_valid_x,
  output logic                    s_ready_x,
  output logic signed [WIDTH-1:0] m_data_out_y,
  output logic                    m_valid_y,
  input  logic                    m_ready_y
);

  localparam int XAW = $clog2(LENX);
  localparam int FAW = $clog2(LENF);
  localparam int KW  = $clog2(LENF + 1);
  localparam int PW  = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_F,
    S_LOAD_X,
    S_COMPUTE,
    S_OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [XAW-1:0] r_cnt;
  logic [XAW-1:0] r_m;
  logic [KW-1:0]  r_k;
  logic           r_f_loaded;

  logic w_f_hs;
  logic w_x_hs;
  logic w_y_hs;
  logic w_cnt_last_f;
  logic w_cnt_last_x;
  logic w_m_last;
  logic w_issue;

  logic [FAW-1:0] w_f_addr;
  logic [XAW-1:0] w_x_addr;

  logic signed [WIDTH-1:0] r_f_mem [LENF];
  logic signed [WIDTH-1:0] r_x_mem [LENX];

  logic signed [WIDTH-1:0] r_f_q_p0;
  logic signed [WIDTH-1:0] r_x_q_p0;
  logic signed [PW-1:0]    w_f_ext;
  logic signed [PW-1:0]    w_x_ext;
  logic signed [PW-1:0]    r_prod_p1;
  logic signed [ACCW-1:0]  w_prod_ext;
  logic signed [ACCW-1:0]  r_acc_p2;
  logic signed [WIDTH-1:0] r_y;

  logic r_vld_p0, r_first_p0, r_last_p0;
  logic r_vld_p1, r_first_p1, r_last_p1;
  logic r_last_p2;

  // Clamp to the signed WIDTH range when SAT is set, otherwise keep the low bits.
  function automatic logic signed [WIDTH-1:0] f_sat_wrap(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] v_max;
    logic signed [ACCW-1:0] v_min;
    v_max = $signed({{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    v_min = $signed({{(ACCW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
    if ((SAT != 0) && (a > v_max)) begin
      return v_max[WIDTH-1:0];
    end else if ((SAT != 0) && (a < v_min)) begin
      return v_min[WIDTH-1:0];
    end
    return a[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] f_relu(input logic signed [WIDTH-1:0] v);
    if ((RELU != 0) && v[WIDTH-1]) begin
      return '0;
    end
    return v;
  endfunction

  assign w_f_hs       = s_valid_f && s_ready_f;
  assign w_x_hs       = s_valid_x && s_ready_x;
  assign w_y_hs       = (r_state == S_OUT) && m_ready_y;
  assign w_cnt_last_f = (r_cnt == XAW'(LENF - 1));
  assign w_cnt_last_x = (r_cnt == XAW'(LENX - 1));
  assign w_m_last     = (r_m == XAW'(LENX - LENF));
  assign w_issue      = (r_state == S_COMPUTE) && (r_k < KW'(LENF));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    s_ready_f = 1'b0;
    s_ready_x = 1'b0;
    m_valid_y = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A pending filter always wins over a pending vector.
        if (s_valid_f) begin
          w_next = S_LOAD_F;
        end else if (r_f_loaded && s_valid_x) begin
          w_next = S_LOAD_X;
        end
      end
      S_LOAD_F: begin
        s_ready_f = 1'b1;
        if (s_valid_f && w_cnt_last_f) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD_X: begin
        s_ready_x = 1'b1;
        if (s_valid_x && w_cnt_last_x) begin
          w_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (r_last_p2) begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        m_valid_y = 1'b1;
        if (m_ready_y) begin
          w_next = w_m_last ? S_IDLE : S_COMPUTE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_m        <= '0;
      r_k        <= '0;
      r_f_loaded <= 1'b0;
    end else begin
      if (w_f_hs) begin
        r_cnt <= w_cnt_last_f ? '0 : r_cnt + 1'b1;
        if (w_cnt_last_f) begin
          r_f_loaded <= 1'b1;
        end
      end else if (w_x_hs) begin
        r_cnt <= w_cnt_last_x ? '0 : r_cnt + 1'b1;
        if (w_cnt_last_x) begin
          r_m <= '0;
        end
      end else if (w_y_hs && !w_m_last) begin
        r_m <= r_m + 1'b1;
      end
      // Tap index restarts every time the block is outside COMPUTE.
      if (r_state != S_COMPUTE) begin
        r_k <= '0;
      end else if (w_issue) begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  // Single-port RAMs: the load counter addresses them while loading, the
  // tap index (plus output position for x) addresses them while computing.
  assign w_f_addr = (r_state == S_LOAD_F) ? FAW'(r_cnt) : FAW'(r_k);
  assign w_x_addr = (r_state == S_LOAD_X) ? r_cnt : r_m + XAW'(r_k);

  // ---- stage p0: synchronous RAM read ----
  always_ff @(posedge clk) begin
    if (w_f_hs) begin
      r_f_mem[w_f_addr] <= s_data_in_f;
    end
    r_f_q_p0 <= r_f_mem[w_f_addr];
  end

  always_ff @(posedge clk) begin
    if (w_x_hs) begin
      r_x_mem[w_x_addr] <= s_data_in_x;
    end
    r_x_q_p0 <= r_x_mem[w_x_addr];
  end

  assign w_f_ext    = $signed({{WIDTH{r_f_q_p0[WIDTH-1]}}, r_f_q_p0});
  assign w_x_ext    = $signed({{WIDTH{r_x_q_p0[WIDTH-1]}}, r_x_q_p0});
  assign w_prod_ext = $signed({{(ACCW-PW){r_prod_p1[PW-1]}}, r_prod_p1});

  // ---- stage p1: full-width product ----
  // ---- stage p2: accumulator, restarted by the first tap's product ----
  always_ff @(posedge clk) begin
    r_prod_p1 <= w_x_ext * w_f_ext;
    if (r_vld_p1) begin
      r_acc_p2 <= (r_first_p1 ? '0 : r_acc_p2) + w_prod_ext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p0   <= 1'b0;
      r_first_p0 <= 1'b0;
      r_last_p0  <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
      r_last_p2  <= 1'b0;
    end else begin
      r_vld_p0   <= w_issue;
      r_first_p0 <= w_issue && (r_k == '0);
      r_last_p0  <= w_issue && (r_k == KW'(LENF - 1));
      r_vld_p1   <= r_vld_p0;
      r_first_p1 <= r_first_p0;
      r_last_p1  <= r_last_p0;
      r_last_p2  <= r_last_p1;
    end
  end

  // ---- output register: final accumulator after saturation/wrap and ReLU ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_y <= '0;
    end else if (r_last_p2) begin
      r_y <= f_relu(f_sat_wrap(r_acc_p2));
    end
  end

  assign m_data_out_y = r_y;

endmodule
